alu_logic_pipe: RTL
===================

# alu_logic_pipe

Parametrised, pipelined successor of the ALU bitwise-AND unit: performs one of eight N-bit bitwise operations per transaction and returns the result with its N/Z/V/C flags over a valid/ready handshake. It also maintains an architectural flags register that is updated only for flag-setting operations. The block sits in the ALU datapath between operand fetch and writeback, and can be stalled by writeback backpressure.

## Interface
- `WIDTH`, default 8: operand and result width in bits, minimum 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands and op are presented.
- `in_ready` output 1: block accepts the transaction this cycle.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B.
- `op` input 3: operation select.
- `set_flags` input 1: commit this result's flags to the flags register.
- `out_valid` output 1: result holding.
- `out_ready` input 1: downstream accepts the result.
- `out` output WIDTH: result.
- `res_flags` output 4: flags of the result on `out`, ordered {n,z,v,c}.
- `flags_n_z_v_c` output 4: architectural flags register.

## Operation
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A.
- Flags per result:
  - n = out[WIDTH-1].
  - z = (out == 0).
  - v = 0 and c = 0 always.
- A transaction is accepted when in_valid && in_ready.
- A result is retired when out_valid && out_ready.
- Pipeline stage: one register slice holding valid, result, res_flags and set_flags.
- in_ready = !stage_valid || out_ready (combinational pass-through of ready; no bubble at full throughput).
- flags_n_z_v_c loads res_flags on the retire cycle only if that transaction's set_flags was 1. Otherwise it holds.
- While out_valid && !out_ready: out, res_flags and out_valid are held stable, and in_ready = 0.
- Simultaneous retire and accept: the stage reloads with the new transaction. out_valid stays 1 and no cycle is lost.
- in_valid is ignored when in_ready = 0. Upstream must hold operands until accepted.

## Timing
- Latency: 1 cycle from accept to out_valid (2 cycles with the macro below).
- Throughput: 1 transaction per cycle when out_ready is held high.
- Reset values: out_valid = 0, out = 0, res_flags = 4'b0000, flags_n_z_v_c = 4'b0000.
- in_ready is 0 while reset is high and 1 on the first cycle after release.
- Reset mid-operation: in-flight results are discarded, not retired, and the flags register is not updated.
- flags_n_z_v_c changes on the clock edge that retires the result. It is visible the following cycle.

## Configuration
- `ALU_LOGIC_PIPE_2STAGE_EN` defined:
  - Two register slices in series; latency 2.
  - Each slice has its own valid and ready. in_ready derives from the first slice.
  - Up to two transactions are in flight. Full throughput is kept.
- Not defined: single slice as described above.
- Flag semantics and retire rules are identical in both builds.

## Structure
- Package `alu_logic_pkg`:
  - Op encoding constants (`OP_AND` … `OP_PASS_A`).
  - Flag bit indices (`FLAG_N` = 3, `FLAG_Z` = 2, `FLAG_V` = 1, `FLAG_C` = 0).
  - Op field width.
- Sub-module `alu_logic_slice`: one valid/ready register slice, parametrised by payload width. Instanced once, or twice under the macro.
- The combinational op decoder and flag generation stay in the top module.

## Test plan
- WIDTH=8, out_ready=1: AND a=0x0F b=0x3C set_flags=1 -> next cycle out=0x0C, res_flags=0000; flags_n_z_v_c=0000 the cycle after.
- NOR a=0x00 b=0x00 set_flags=1 -> out=0xFF, res_flags=1000, flags register becomes 1000. Then XOR a=0x55 b=0x55 set_flags=0 -> out=0x00, res_flags=0100, flags register stays 1000.
- Backpressure: accept OR a=0x01 b=0x02, hold out_ready=0 for 3 cycles -> out=0x03 stable, in_ready=0 throughout, and a presented ANDN is not accepted. Raise out_ready -> retire, with ANDN accepted the same cycle.
- Streaming: 16 back-to-back random ops with out_ready=1 -> 16 results in order, one per cycle, each matching the reference model including res_flags.
- Reset mid-flight: accept NAND a=0xFF b=0xFF set_flags=1, assert reset before retire -> out_valid=0, out=0, flags_n_z_v_c=0000, no retire observed.
- WIDTH=1 and WIDTH=32 builds, each with and without `ALU_LOGIC_PIPE_2STAGE_EN`:
  - PASS_A a=MSB-only -> n=1, z=0.
  - Latency measured as 1 or 2 cycles respectively.

Source files
------------

// File: rtl/alu_logic_pkg.sv
// Shared constants for the pipelined bitwise ALU: op encodings, flag bit indices, op field width.
// Pure definitions; no latency or backpressure of its own.
package alu_logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_ANDN   = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_logic_slice.sv
// One valid/ready register slice carrying an opaque W-bit payload.
// Latency 1; in_ready = !out_valid || out_ready, so a full slice stalls only while downstream stalls.
module alu_logic_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_dat
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_dat   <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_dat <= in_dat;
    end
  end

endmodule

// File: rtl/alu_logic_pipe.sv
// Pipelined 8-op bitwise ALU with per-result N/Z/V/C flags and an architectural flags register.
// Latency 1 (2 with ALU_LOGIC_PIPE_2STAGE_EN); out held and in_ready low while out_valid && !out_ready.
module alu_logic_pipe
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  op,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       res_flags,
  output logic [3:0]       flags_n_z_v_c
);

  // Payload layout: {set_flags, res_flags[3:0], result}
  localparam int PW = WIDTH + 5;

  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [PW-1:0]    in_dat;
  logic [PW-1:0]    out_dat;
  logic             head_rdy;

  always_comb begin
    result = '0;
    case (op)
      OP_AND:    result = in_a & in_b;
      OP_OR:     result = in_a | in_b;
      OP_XOR:    result = in_a ^ in_b;
      OP_NAND:   result = ~(in_a & in_b);
      OP_NOR:    result = ~(in_a | in_b);
      OP_XNOR:   result = ~(in_a ^ in_b);
      OP_ANDN:   result = in_a & ~in_b;
      OP_PASS_A: result = in_a;
      default:   result = '0;
    endcase
  end

  always_comb begin
    flags         = 4'b0000;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_V] = 1'b0;
    flags[FLAG_C] = 1'b0;
  end

  assign in_dat   = {set_flags, flags, result};
  // The slice alone would report ready during reset; hold off upstream until released.
  assign in_ready = head_rdy && !reset;

`ifdef ALU_LOGIC_PIPE_2STAGE_EN
  logic          mid_vld;
  logic          mid_rdy;
  logic [PW-1:0] mid_dat;

  alu_logic_slice #(.W(PW)) u_slice0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (head_rdy),
    .in_dat    (in_dat),
    .out_valid (mid_vld),
    .out_ready (mid_rdy),
    .out_dat   (mid_dat)
  );

  alu_logic_slice #(.W(PW)) u_slice1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mid_vld),
    .in_ready  (mid_rdy),
    .in_dat    (mid_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dat   (out_dat)
  );
`else
  alu_logic_slice #(.W(PW)) u_slice0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (head_rdy),
    .in_dat    (in_dat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dat   (out_dat)
  );
`endif

  assign out       = out_dat[WIDTH-1:0];
  assign res_flags = out_dat[WIDTH+3:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_n_z_v_c <= 4'b0000;
    end else if (out_valid && out_ready && out_dat[PW-1]) begin
      flags_n_z_v_c <= out_dat[WIDTH+3:WIDTH];
    end
  end

endmodule
